switch_input_port: RTL and testbench
====================================

Name: switch_input_port

Overview:
- Input-side counterpart of the R15 display path: turns the raw external switch bank plus a load pushbutton into clean, one-shot data words for the datapath's external-input operand.
- Synchronizes switches and button, debounces the button, captures the switch value on each debounced press, and holds it under a valid/ready handshake until the datapath consumes it.
- Sits between board I/O and the decoder/datapath input mux, in the divided-clock domain.

Parameters:
- DATA_W, 8, width of switch bank and captured word
- SYNC_STAGES, 2, flip-flop synchronizer depth for switches and button (minimum 2)
- DEBOUNCE_CYCLES, 16, consecutive stable clk cycles required before the debounced button level changes (minimum 2)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-low reset
- sw_in  input  DATA_W  raw asynchronous switch bank
- load_btn  input  1  raw asynchronous load pushbutton, active-high
- data_ready  input  1  consumer can accept data_out this cycle
- data_out  output  DATA_W  captured switch word; stable while data_valid=1
- data_valid  output  1  data_out holds an unconsumed word
- btn_level  output  1  debounced button level
- overrun  output  1  sticky; a press was dropped because a word was still pending

Behaviour:
- Reset (rst=0 at clk edge): all synchronizer flops 0, debounce counter 0, btn_level=0, data_out=0, data_valid=0, overrun=0, FSM=IDLE.
- Synchronizers: sw_in and load_btn each pass through SYNC_STAGES flops. sw_sync and btn_sync are the last-stage outputs.
- Debounce:
  - If btn_sync == btn_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, btn_level takes btn_sync and the counter clears.
  - Latency from a clean raw edge to a btn_level change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. btn_level never toggles on it.
- Press event: a single-cycle pulse when btn_level goes 0->1. A 1->0 transition generates nothing.
- FSM:
  - IDLE: on a press, data_out <= sw_sync, data_valid <= 1, go to PENDING.
  - PENDING, data_valid=1:
    - data_out and data_valid are held.
    - Handshake completes on any cycle with data_valid & data_ready.
    - On completion without a press in the same cycle: data_valid <= 0, go to IDLE.
    - On completion with a press in the same cycle: recapture sw_sync into data_out, keep data_valid=1, stay in PENDING, leave overrun unchanged.
    - On a press without completion: the press is dropped, data_out is unchanged, overrun <= 1.
- overrun stays set until reset. It does not block further captures.
- data_ready is ignored while data_valid=0.
- Holding the button captures exactly once; a new capture needs release then re-press, both debounced.
- Reset mid-operation clears any pending word with no handshake.
- A button held through reset release is seen as a press after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Width: data_out is a straight copy of sw_sync. No arithmetic on data.

Optional Feature:
- Macro: SWITCH_AUTO_LOAD_EN.
- When defined:
  - A second debounce tracker watches sw_sync. It has its own counter and uses the same DEBOUNCE_CYCLES.
  - A settled change of the switch word, i.e. a new value held for DEBOUNCE_CYCLES cycles, generates a capture event identical to a press: same FSM, handshake and overrun rules.
  - A press and an auto event in the same cycle count as one event.
  - At reset the tracked value is 0, so a nonzero bank generates one auto event after settling.
- When undefined: only button presses capture, and no switch-tracking logic exists.

Test Plan:
- DEBOUNCE_CYCLES=4. sw_in=8'hA5; raise load_btn, hold 20 cycles, data_ready=0 -> data_valid rises 6 cycles after the raw edge (2 sync + 4 debounce), data_out=8'hA5, exactly one capture; then data_ready=1 for one cycle -> data_valid=0 next cycle.
- 3-cycle glitch pulses on load_btn, repeated 5 times -> btn_level stays 0, data_valid stays 0.
- Capture 8'h3C and leave it unconsumed; set sw_in=8'hFF and do a full second press -> data_out stays 8'h3C, overrun=1; data_ready=1 -> data_valid=0, overrun still 1.
- Pending 8'h11; sw_in=8'h22; align data_ready=1 with the cycle the second press pulses -> data_out=8'h22, data_valid stays 1, overrun=0.
- Pending 8'h5A; drive rst=0 for one cycle while load_btn is still held -> all outputs 0 next cycle; after release a new press is detected 6 cycles later and captures the current sw_in.
- With SWITCH_AUTO_LOAD_EN defined: change sw_in from 8'h00 to 8'h81 with no button -> data_valid=1 with data_out=8'h81 after settling; bouncing sw_in for under 4 cycles -> no capture.

Source files
------------

// File: rtl/switch_input_port.sv
`default_nettype none
// ============================================================================
// Module      : switch_input_port
// Description : Turns the raw switch bank and load pushbutton into one-shot
//               data words for the datapath's external-input operand.
//               Switches and button are synchronized, the button is
//               debounced, and each debounced press captures the switch word.
//               The word is held under a valid/ready handshake until the
//               datapath consumes it.
// Ports       : clk        - system clock (divided domain), rising edge
//               rst        - synchronous, active-low reset
//               sw_in      - raw asynchronous switch bank [DATA_W]
//               load_btn   - raw asynchronous load pushbutton, active-high
//               data_ready - consumer accepts data_out this cycle
//               data_out   - captured switch word, stable while data_valid
//               data_valid - data_out holds an unconsumed word
//               btn_level  - debounced button level
//               overrun    - sticky, a press was dropped while a word pended
// Options     : SWITCH_AUTO_LOAD_EN - a settled change of the switch word
//               also triggers a capture, exactly like a button press.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_input_port #(
    parameter int DATA_W          = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              load_btn,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              btn_level,
    output logic              overrun
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (index 0 is the first stage)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sw_sync;
    logic [SYNC_STAGES-1:0]             r_btn_sync;
    logic [DATA_W-1:0]                  w_sw_sync;
    logic                               w_btn_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_sync  <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], sw_in};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], load_btn};
        end
    end

    assign w_sw_sync  = r_sw_sync[SYNC_STAGES-1];
    assign w_btn_sync = r_btn_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Button debounce: the counter only runs while the synchronized level
    // disagrees with the debounced level, so any return to agreement
    // restarts it.
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_btn_cnt;
    logic               r_btn_level;
    logic               w_btn_settle;
    logic               w_press;

    // The press is flagged on the same edge btn_level rises, so the capture
    // lands together with the level change.
    assign w_btn_settle = (w_btn_sync != r_btn_level) && (r_btn_cnt == c_CNT_MAX);
    assign w_press      = w_btn_settle && w_btn_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_btn_cnt   <= '0;
            r_btn_level <= 1'b0;
        end else if (w_btn_sync == r_btn_level) begin
            r_btn_cnt   <= '0;
        end else if (r_btn_cnt == c_CNT_MAX) begin
            r_btn_level <= w_btn_sync;
            r_btn_cnt   <= '0;
        end else begin
            r_btn_cnt   <= r_btn_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Capture event source
    // ------------------------------------------------------------------
    logic w_event;

`ifdef SWITCH_AUTO_LOAD_EN
    // Switch-word tracker. A word must stay identical for the full debounce
    // window; any movement, even to another non-tracked value, restarts the
    // count with the moved-to cycle counted as the first.
    logic [DATA_W-1:0]  r_sw_level;
    logic [DATA_W-1:0]  r_sw_prev;
    logic [c_CNT_W-1:0] r_sw_cnt;
    logic               w_sw_diff;
    logic               w_sw_moved;
    logic               w_auto;

    assign w_sw_diff  = (w_sw_sync != r_sw_level);
    assign w_sw_moved = (w_sw_sync != r_sw_prev);
    assign w_auto     = w_sw_diff && !w_sw_moved && (r_sw_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_level <= '0;
            r_sw_prev  <= '0;
            r_sw_cnt   <= '0;
        end else begin
            r_sw_prev <= w_sw_sync;
            if (!w_sw_diff) begin
                r_sw_cnt   <= '0;
            end else if (w_sw_moved) begin
                r_sw_cnt   <= c_CNT_W'(1);
            end else if (r_sw_cnt == c_CNT_MAX) begin
                r_sw_level <= w_sw_sync;
                r_sw_cnt   <= '0;
            end else begin
                r_sw_cnt   <= r_sw_cnt + 1'b1;
            end
        end
    end

    // Coincident press and auto event collapse into one capture.
    assign w_event = w_press | w_auto;
`else
    assign w_event = w_press;
`endif

    // ------------------------------------------------------------------
    // Capture / handshake FSM
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic              w_handshake;

    assign w_handshake = r_valid && data_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        case (r_state)
            IDLE: begin
                if (w_event) begin
                    w_data_nxt  = w_sw_sync;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (w_handshake) begin
                    // A press on the consuming cycle refills the slot
                    // directly, so nothing is lost and no overrun occurs.
                    if (w_event) begin
                        w_data_nxt  = w_sw_sync;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else if (w_event) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign btn_level  = r_btn_level;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_switch_input_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_input_port
// Description : Self-checking bench for switch_input_port with
//               DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 (press latency 6 cycles).
//               A per-cycle vector table covers the basic capture, hold,
//               consume, release and glitch behaviour; short hand-written
//               sequences cover overrun, same-cycle refill and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_input_port;

    localparam int c_DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_DW-1:0] sw_in;
    logic            load_btn;
    logic            data_ready;
    logic [c_DW-1:0] data_out;
    logic            data_valid;
    logic            btn_level;
    logic            overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    switch_input_port #(
        .DATA_W          (c_DW),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .load_btn   (load_btn),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .btn_level  (btn_level),
        .overrun    (overrun)
    );

    typedef struct {
        logic [c_DW-1:0] sw;
        logic            btn;
        logic            rdy;
        logic            exp_valid;
        logic [c_DW-1:0] exp_data;
        logic            chk_data;
        logic            exp_level;
        logic            exp_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [c_DW-1:0] sw, input logic btn,
                                input logic rdy, input logic ev,
                                input logic [c_DW-1:0] ed, input logic cd,
                                input logic el, input logic eo);
        vec_t v;
        v.sw = sw; v.btn = btn; v.rdy = rdy; v.exp_valid = ev;
        v.exp_data = ed; v.chk_data = cd; v.exp_level = el; v.exp_ovr = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        sw_in      = '0;
        load_btn   = 1'b0;
        data_ready = 1'b0;
        step(2);
        check("reset data_out",   data_out,   0);
        check("reset data_valid", data_valid, 0);
        check("reset btn_level",  btn_level,  0);
        check("reset overrun",    overrun,    0);
        rst = 1'b1;
        step(2);

        // Row k is applied before edge k+1 and checked just after it.
        // Press held 20 cycles: capture on the 6th edge, exactly once.
        for (int i = 0; i < 20; i++)
            add(8'hA5, 1'b1, 1'b0, i >= 5, 8'hA5, i >= 5, i >= 5, 1'b0);
        // Release and consume together; the release needs 6 edges to settle.
        add(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 21; i < 25; i++)
            add(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 25; i < 27; i++)
            add(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Five 3-cycle glitches: never long enough to move btn_level.
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 6; i++)
                add(8'h77, i < 3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            add(8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            sw_in      = vecs[i].sw;
            load_btn   = vecs[i].btn;
            data_ready = vecs[i].rdy;
            step(1);
            check($sformatf("vec%0d valid", i), data_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d level", i), btn_level,  vecs[i].exp_level);
            check($sformatf("vec%0d ovr", i),   overrun,    vecs[i].exp_ovr);
            if (vecs[i].chk_data)
                check($sformatf("vec%0d data", i), data_out, vecs[i].exp_data);
        end
        data_ready = 1'b0;

        // Overrun: second full press while 8'h3C is still pending.
        sw_in = 8'h3C; load_btn = 1'b1;
        step(6);
        check("ovr first valid", data_valid, 1);
        check("ovr first data",  data_out,   8'h3C);
        step(2); load_btn = 1'b0; step(8);
        sw_in = 8'hFF; load_btn = 1'b1;
        step(10); load_btn = 1'b0; step(8);
        check("ovr held data",  data_out,   8'h3C);
        check("ovr held valid", data_valid, 1);
        check("ovr flag set",   overrun,    1);
        data_ready = 1'b1; step(1); data_ready = 1'b0;
        check("ovr consumed valid", data_valid, 0);
        check("ovr sticky",         overrun,    1);

        rst = 1'b0; step(1); rst = 1'b1;
        check("rst clears overrun", overrun,    0);
        check("rst clears valid",   data_valid, 0);

        // Consume and press on the same edge: refill without overrun.
        sw_in = 8'h11; load_btn = 1'b1;
        step(6);
        check("refill first data", data_out, 8'h11);
        load_btn = 1'b0; step(8);
        sw_in = 8'h22; load_btn = 1'b1;
        step(5);
        check("refill pre data",  data_out,   8'h11);
        check("refill pre valid", data_valid, 1);
        data_ready = 1'b1; step(1); data_ready = 1'b0;
        check("refill data",  data_out,   8'h22);
        check("refill valid", data_valid, 1);
        check("refill ovr",   overrun,    0);
        step(1);
        check("refill still valid", data_valid, 1);
        load_btn = 1'b0; step(8);
        data_ready = 1'b1; step(1); data_ready = 1'b0;
        check("refill consumed", data_valid, 0);

        // Reset mid-operation with the button held through it.
        sw_in = 8'h5A; load_btn = 1'b1;
        step(6);
        check("midrst pending data", data_out, 8'h5A);
        step(2);
        rst = 1'b0; step(1);
        check("midrst data",  data_out,   0);
        check("midrst valid", data_valid, 0);
        check("midrst level", btn_level,  0);
        check("midrst ovr",   overrun,    0);
        rst = 1'b1; sw_in = 8'hC3;
        step(5);
        check("midrst early valid", data_valid, 0);
        check("midrst early level", btn_level,  0);
        step(1);
        check("midrst repress valid", data_valid, 1);
        check("midrst repress data",  data_out,   8'hC3);
        check("midrst repress level", btn_level,  1);
        load_btn = 1'b0; step(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
